decoder_mem_arbiter: RTL and testbench
======================================

Name: decoder_mem_arbiter

Overview:
- Shares one downstream dmem port between the decoder LSU's three request channels: bitstream buffer (ch0), frame RAM0 (ch1) and frame RAM1 (ch2).
- Arbitrates requests round-robin and forwards the winner to the port with zero added latency.
- Records the winning channel ID in an in-order tag FIFO and routes each response back to the channel that issued it.
- Sits between the decoder LSU and the accelerator memory-port interface.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 64, request and response data width.
- MAX_OUTSTANDING, 4, tag FIFO depth, i.e. the maximum number of accepted requests awaiting a response (power of two, ≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- chN_req_valid_i  in  1  request valid, N=0..2
- chN_req_addr_i  in  ADDR_WIDTH  request address
- chN_req_wmask_i  in  DATA_WIDTH/8  byte write mask
- chN_req_data_i  in  DATA_WIDTH  write data
- chN_req_cmd_i  in  1  1=read, 0=write
- chN_req_ready_o  out  1  request accepted this cycle
- chN_rsp_valid_o  out  1  routed response valid
- chN_rsp_data_o  out  DATA_WIDTH  routed response data
- chN_rsp_err_o  out  1  routed response error
- mem_req_valid_o  out  1  downstream request valid
- mem_req_addr_o  out  ADDR_WIDTH  downstream address
- mem_req_wmask_o  out  DATA_WIDTH/8  downstream byte mask
- mem_req_data_o  out  DATA_WIDTH  downstream write data
- mem_req_cmd_o  out  1  downstream command
- mem_req_ready_i  in  1  downstream accept
- mem_rsp_valid_i  in  1  downstream response valid
- mem_rsp_data_i  in  DATA_WIDTH  downstream response data
- mem_rsp_err_i  in  1  downstream response error
- orphan_rsp_o  out  1  sticky flag: a response arrived with the tag FIFO empty
- busy_o  out  1  tag FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: rr_ptr=0, lock clear, FIFO empty (count=0), orphan_rsp_o=0.
- Outputs while rst_i is high: all outputs 0. Accepted-but-unanswered requests are discarded. Responses arriving after reset with the FIFO empty count as orphans.
- Command convention: every accepted request, read or write, returns exactly one response, in request order.
- Grant selection (combinational):
  - If lock is set, the grant is the locked channel.
  - Otherwise the grant is the first valid channel scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- Downstream request: mem_req_valid_o = (any channel valid) & can_push. The address, mask, data and cmd fields come from the granted channel. They are 0 when no channel is valid.
- can_push = (count < MAX_OUTSTANDING) | mem_rsp_valid_i. A same-cycle pop frees a slot when the FIFO is full.
- Ready: chN_req_ready_o = grant==N & mem_req_valid_o & mem_req_ready_i. Only one ready is asserted per cycle.
- Accept (fire): push the grant ID into the FIFO, set rr_ptr=(grant+1) mod 3, clear lock.
- Stall: if mem_req_valid_o=1 and mem_req_ready_i=0, set lock to the grant. This holds the downstream request stable until it is accepted, with no re-arbitration.
- Blocked by a full FIFO: mem_req_valid_o=0, so lock is not set and arbitration is re-evaluated next cycle.
- Response routing:
  - On mem_rsp_valid_i with the FIFO non-empty, pop the head ID H. Drive chH_rsp_valid_o=1 with data and err passed through in the same cycle.
  - Other channels' rsp_valid outputs are 0. Data outputs of non-selected channels are 0.
- Orphan response: mem_rsp_valid_i with the FIFO empty and no same-cycle push ahead of it. The response is dropped, no channel valid is asserted, and orphan_rsp_o is set. The flag clears only on reset.
- Simultaneous push and pop: count is unchanged, the head is popped, and the new ID is appended at the tail.
- Same-cycle push into an empty FIFO with a response present: the response is orphaned. The new ID is not bypassed.
- Counter widths: count is clog2(MAX_OUTSTANDING)+1 bits. FIFO pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro: DECODER_MEM_ARB_PERF_EN.
- When defined, adds the following outputs, each cleared by reset:
  - grant_cnt0_o, grant_cnt1_o, grant_cnt2_o: 32 bits each, incrementing on each accept by that channel.
  - stall_cnt_o: 32 bits, incrementing each cycle where any channel is valid and no request is accepted.
  - All counters saturate at 0xFFFFFFFF.
- When undefined, these ports and their logic are absent and the remaining behaviour is identical.

Test Plan:
- Reset: hold rst_i for 2 cycles with all chN valid=1 -> all ready, mem_req_valid_o, rsp_valid and orphan_rsp_o are 0. On the first cycle after reset, ch0 is granted.
- Round-robin: all three channels valid continuously, mem_req_ready_i=1, responses returned 1 cycle later -> grant sequence 0,1,2,0,1,2. Each response is routed to the issuing channel in order.
- Stall lock: ch1 valid with mem_req_ready_i=0 for 3 cycles, ch0 raises valid in cycle 2 -> addr/cmd stay at ch1 values for all 3 cycles. ch1_req_ready_o pulses when ready rises, then ch2 is granted if valid, else ch0.
- Full FIFO: MAX_OUTSTANDING=4 with 4 accepted reads and no response -> mem_req_valid_o=0 and busy_o=1. A response for ch2 with data 0xDEADBEEF_00000001 in the same cycle as a pending ch0 request -> ch2_rsp_valid_o=1 with that data, and the ch0 request is accepted in the same cycle.
- Error and orphan: a response with mem_rsp_err_i=1 for ch1 -> ch1_rsp_err_o=1. An extra response with the FIFO empty -> no chN_rsp_valid_o, orphan_rsp_o=1 sticky until rst_i.
- Perf (macro on): 10 accepts for ch0, 5 for ch2 and 7 stall cycles -> grant_cnt0_o=10, grant_cnt2_o=5, stall_cnt_o=7.

Source files
------------

// File: rtl/decoder_mem_arbiter_if.sv
// Downstream dmem port bundle between the LSU arbiter (master) and the memory-port interface (slave).
interface decoder_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  // A request transfers on a cycle where req_valid & req_ready are both high; once valid
  // rises the master holds every request field stable until that cycle. Responses carry
  // no ready: rsp_valid is a single-cycle pulse the master must always consume.
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH/8-1:0] req_wmask;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    req_cmd;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_err;

  modport master (
    output req_valid, req_addr, req_wmask, req_data, req_cmd,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wmask, req_data, req_cmd,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/decoder_mem_arbiter.sv
// Round-robin arbiter sharing one dmem port between three LSU channels, with in-order response routing.
// Optional performance counters are enabled by defining DECODER_MEM_ARB_PERF_EN.
module decoder_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ch0_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ch0_req_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ch0_req_wmask_i,
  input  logic [DATA_WIDTH-1:0]   ch0_req_data_i,
  input  logic                    ch0_req_cmd_i,
  output logic                    ch0_req_ready_o,
  output logic                    ch0_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ch0_rsp_data_o,
  output logic                    ch0_rsp_err_o,
  input  logic                    ch1_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ch1_req_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ch1_req_wmask_i,
  input  logic [DATA_WIDTH-1:0]   ch1_req_data_i,
  input  logic                    ch1_req_cmd_i,
  output logic                    ch1_req_ready_o,
  output logic                    ch1_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ch1_rsp_data_o,
  output logic                    ch1_rsp_err_o,
  input  logic                    ch2_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   ch2_req_addr_i,
  input  logic [DATA_WIDTH/8-1:0] ch2_req_wmask_i,
  input  logic [DATA_WIDTH-1:0]   ch2_req_data_i,
  input  logic                    ch2_req_cmd_i,
  output logic                    ch2_req_ready_o,
  output logic                    ch2_rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   ch2_rsp_data_o,
  output logic                    ch2_rsp_err_o,
  decoder_mem_arbiter_if.master   mem,
  output logic                    orphan_rsp_o,
  output logic                    busy_o
`ifdef DECODER_MEM_ARB_PERF_EN
  ,
  output logic [31:0]             grant_cnt0_o,
  output logic [31:0]             grant_cnt1_o,
  output logic [31:0]             grant_cnt2_o,
  output logic [31:0]             stall_cnt_o
`endif
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  logic [2:0]              vld;
  logic [ADDR_WIDTH-1:0]   addr_a  [3];
  logic [DATA_WIDTH/8-1:0] wmask_a [3];
  logic [DATA_WIDTH-1:0]   data_a  [3];
  logic [2:0]              cmd_a;

  assign vld        = {ch2_req_valid_i, ch1_req_valid_i, ch0_req_valid_i};
  assign cmd_a      = {ch2_req_cmd_i, ch1_req_cmd_i, ch0_req_cmd_i};
  assign addr_a[0]  = ch0_req_addr_i;
  assign addr_a[1]  = ch1_req_addr_i;
  assign addr_a[2]  = ch2_req_addr_i;
  assign wmask_a[0] = ch0_req_wmask_i;
  assign wmask_a[1] = ch1_req_wmask_i;
  assign wmask_a[2] = ch2_req_wmask_i;
  assign data_a[0]  = ch0_req_data_i;
  assign data_a[1]  = ch1_req_data_i;
  assign data_a[2]  = ch2_req_data_i;

  logic [1:0]    rr_q, rr_d, lock_ch_q, lock_ch_d;
  logic          lock_q, lock_d, orphan_q, orphan_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    tag_q [MAX_OUTSTANDING];
  logic [1:0]    tag_d [MAX_OUTSTANDING];

  logic [1:0] grant, cand, head;
  logic       found, any_valid, can_push, req_valid, fire, fifo_empty, pop;
  logic [2:0] ready_v, rsp_v;

  // A stalled request keeps its grant so the downstream fields cannot change under it.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    cand  = rr_q;
    if (lock_q) begin
      grant = lock_ch_q;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!found && vld[cand]) begin
          grant = cand;
          found = 1'b1;
        end
        cand = next_ch(cand);
      end
    end
  end

  assign any_valid  = (|vld) & ~rst_i;
  assign fifo_empty = (count_q == '0);
  // A response pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign can_push   = (count_q < CW'(MAX_OUTSTANDING)) | mem.rsp_valid;
  assign req_valid  = any_valid & can_push;
  assign fire       = req_valid & mem.req_ready;
  assign pop        = mem.rsp_valid & ~fifo_empty & ~rst_i;
  assign head       = tag_q[rd_ptr_q];

  always_comb begin
    mem.req_valid = req_valid;
    mem.req_addr  = any_valid ? addr_a[grant]  : '0;
    mem.req_wmask = any_valid ? wmask_a[grant] : '0;
    mem.req_data  = any_valid ? data_a[grant]  : '0;
    mem.req_cmd   = any_valid ? cmd_a[grant]   : 1'b0;
    ready_v       = 3'b000;
    rsp_v         = 3'b000;
    if (fire) ready_v[grant] = 1'b1;
    if (pop)  rsp_v[head]    = 1'b1;
  end

  assign ch0_req_ready_o = ready_v[0];
  assign ch1_req_ready_o = ready_v[1];
  assign ch2_req_ready_o = ready_v[2];
  assign ch0_rsp_valid_o = rsp_v[0];
  assign ch1_rsp_valid_o = rsp_v[1];
  assign ch2_rsp_valid_o = rsp_v[2];
  assign ch0_rsp_data_o  = rsp_v[0] ? mem.rsp_data : '0;
  assign ch1_rsp_data_o  = rsp_v[1] ? mem.rsp_data : '0;
  assign ch2_rsp_data_o  = rsp_v[2] ? mem.rsp_data : '0;
  assign ch0_rsp_err_o   = rsp_v[0] & mem.rsp_err;
  assign ch1_rsp_err_o   = rsp_v[1] & mem.rsp_err;
  assign ch2_rsp_err_o   = rsp_v[2] & mem.rsp_err;
  assign busy_o          = ~fifo_empty & ~rst_i;
  assign orphan_rsp_o    = orphan_q & ~rst_i;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_d     = tag_q;
    orphan_d  = orphan_q;
    count_d   = count_q;
    if (fire) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      rr_d            = next_ch(grant);
      lock_d          = 1'b0;
    end else if (req_valid) begin
      lock_d    = 1'b1;
      lock_ch_d = grant;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // A push into an empty FIFO is not bypassed: the coincident response is an orphan.
    if (mem.rsp_valid && fifo_empty) orphan_d = 1'b1;
    case ({fire, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= 2'd0;
      lock_q    <= 1'b0;
      lock_ch_q <= 2'd0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_q     <= '{default: 2'd0};
      orphan_q  <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tag_q     <= tag_d;
      orphan_q  <= orphan_d;
    end
  end

`ifdef DECODER_MEM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, gcnt2_q, gcnt2_d, stall_q, stall_d;

  always_comb begin
    gcnt0_d = ready_v[0] ? sat_inc(gcnt0_q) : gcnt0_q;
    gcnt1_d = ready_v[1] ? sat_inc(gcnt1_q) : gcnt1_q;
    gcnt2_d = ready_v[2] ? sat_inc(gcnt2_q) : gcnt2_q;
    stall_d = (any_valid && !fire) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gcnt0_q <= 32'd0;
      gcnt1_q <= 32'd0;
      gcnt2_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      gcnt2_q <= gcnt2_d;
      stall_q <= stall_d;
    end
  end

  assign grant_cnt0_o = rst_i ? 32'd0 : gcnt0_q;
  assign grant_cnt1_o = rst_i ? 32'd0 : gcnt1_q;
  assign grant_cnt2_o = rst_i ? 32'd0 : gcnt2_q;
  assign stall_cnt_o  = rst_i ? 32'd0 : stall_q;
`endif
endmodule

// File: tb/tb_decoder_mem_arbiter.sv
// Directed bench for decoder_mem_arbiter: a per-cycle vector table plus hand-written reset/orphan sequences.
module tb_decoder_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    vld;
  logic [AW-1:0] ch_addr  [3];
  logic [DW/8-1:0] ch_wmask [3];
  logic [DW-1:0] ch_data  [3];
  logic [2:0]    ch_cmd;
  logic [2:0]    rdy_v, rspv_v, rerr_v;
  logic [DW-1:0] rdata_o [3];
  logic          orphan, busy;
  logic [31:0]   gc0, gc1, gc2, sc;

  decoder_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  decoder_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch0_req_valid_i(vld[0]), .ch0_req_addr_i(ch_addr[0]), .ch0_req_wmask_i(ch_wmask[0]),
    .ch0_req_data_i(ch_data[0]), .ch0_req_cmd_i(ch_cmd[0]), .ch0_req_ready_o(rdy_v[0]),
    .ch0_rsp_valid_o(rspv_v[0]), .ch0_rsp_data_o(rdata_o[0]), .ch0_rsp_err_o(rerr_v[0]),
    .ch1_req_valid_i(vld[1]), .ch1_req_addr_i(ch_addr[1]), .ch1_req_wmask_i(ch_wmask[1]),
    .ch1_req_data_i(ch_data[1]), .ch1_req_cmd_i(ch_cmd[1]), .ch1_req_ready_o(rdy_v[1]),
    .ch1_rsp_valid_o(rspv_v[1]), .ch1_rsp_data_o(rdata_o[1]), .ch1_rsp_err_o(rerr_v[1]),
    .ch2_req_valid_i(vld[2]), .ch2_req_addr_i(ch_addr[2]), .ch2_req_wmask_i(ch_wmask[2]),
    .ch2_req_data_i(ch_data[2]), .ch2_req_cmd_i(ch_cmd[2]), .ch2_req_ready_o(rdy_v[2]),
    .ch2_rsp_valid_o(rspv_v[2]), .ch2_rsp_data_o(rdata_o[2]), .ch2_rsp_err_o(rerr_v[2]),
    .mem(mem_if),
    .orphan_rsp_o(orphan), .busy_o(busy)
`ifdef DECODER_MEM_ARB_PERF_EN
    , .grant_cnt0_o(gc0), .grant_cnt1_o(gc1), .grant_cnt2_o(gc2), .stall_cnt_o(sc)
`endif
  );

`ifndef DECODER_MEM_ARB_PERF_EN
  assign gc0 = 32'd0;
  assign gc1 = 32'd0;
  assign gc2 = 32'd0;
  assign sc  = 32'd0;
`endif

  typedef struct {
    logic [2:0]    vld;
    logic          rdy;
    logic          rspv;
    logic          rerr;
    logic [DW-1:0] rdata;
    logic          mval;
    logic [1:0]    g;      // 3 = no channel valid
    logic [2:0]    rdyv;
    logic [2:0]    rspvv;
    logic          busy;
    logic          orph;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic r, input logic [2:0] v, input logic rd,
                       input logic rv, input logic re, input logic [DW-1:0] rdat);
    @(negedge clk);
    rst = r;
    vld = v;
    mem_if.req_ready = rd;
    mem_if.rsp_valid = rv;
    mem_if.rsp_err   = re;
    mem_if.rsp_data  = rdat;
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mval"}, {63'd0, mem_if.req_valid}, 64'd0);
    chk({tag, "_ready"}, {61'd0, rdy_v}, 64'd0);
    chk({tag, "_rspv"}, {61'd0, rspv_v}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_orphan"}, {63'd0, orphan}, 64'd0);
    chk({tag, "_addr"}, {32'd0, mem_if.req_addr}, 64'd0);
  endtask

  task automatic chk_vec(input int i, input vec_t v);
    logic [AW-1:0]   ea;
    logic [DW/8-1:0] em;
    logic [DW-1:0]   ed;
    logic            ec;
    string t;
    t  = $sformatf("v%0d", i);
    ea = (v.g == 2'd3) ? '0 : ch_addr[v.g];
    em = (v.g == 2'd3) ? '0 : ch_wmask[v.g];
    ed = (v.g == 2'd3) ? '0 : ch_data[v.g];
    ec = (v.g == 2'd3) ? 1'b0 : ch_cmd[v.g];
    chk({t, "_mval"},  {63'd0, mem_if.req_valid}, {63'd0, v.mval});
    chk({t, "_addr"},  {32'd0, mem_if.req_addr}, {32'd0, ea});
    chk({t, "_wmask"}, {56'd0, mem_if.req_wmask}, {56'd0, em});
    chk({t, "_wdata"}, mem_if.req_data, ed);
    chk({t, "_cmd"},   {63'd0, mem_if.req_cmd}, {63'd0, ec});
    chk({t, "_ready"}, {61'd0, rdy_v}, {61'd0, v.rdyv});
    chk({t, "_rspv"},  {61'd0, rspv_v}, {61'd0, v.rspvv});
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s_rdata%0d", t, c), rdata_o[c], v.rspvv[c] ? v.rdata : 64'd0);
      chk($sformatf("%s_rerr%0d", t, c), {63'd0, rerr_v[c]}, {63'd0, v.rspvv[c] & v.rerr});
    end
    chk({t, "_busy"},   {63'd0, busy}, {63'd0, v.busy});
    chk({t, "_orphan"}, {63'd0, orphan}, {63'd0, v.orph});
  endtask

  initial begin
    ch_addr[0]  = 32'h0000_1000; ch_addr[1]  = 32'h0000_2000; ch_addr[2]  = 32'h0000_3000;
    ch_wmask[0] = 8'h0F;         ch_wmask[1] = 8'hF0;         ch_wmask[2] = 8'hFF;
    ch_data[0]  = 64'hA0A0_0000_0000_00A0;
    ch_data[1]  = 64'hB1B1_0000_0000_00B1;
    ch_data[2]  = 64'hC2C2_0000_0000_00C2;
    ch_cmd      = 3'b101;
    vld = 3'b000;
    mem_if.req_ready = 1'b0; mem_if.rsp_valid = 1'b0;
    mem_if.rsp_err = 1'b0;   mem_if.rsp_data = '0;

    //            vld    rdy   rspv  rerr  rdata                       mval  g     rdyv    rspvv   busy  orph
    vecs[0]  = '{3'b111, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{3'b111, 1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0001,    1'b1, 2'd1, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[2]  = '{3'b111, 1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0002,    1'b1, 2'd2, 3'b100, 3'b010, 1'b1, 1'b0};
    vecs[3]  = '{3'b111, 1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0003,    1'b1, 2'd0, 3'b001, 3'b100, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0004,    1'b1, 2'd1, 3'b010, 3'b001, 1'b1, 1'b0};
    vecs[5]  = '{3'b111, 1'b1, 1'b1, 1'b0, 64'h1111_0000_0000_0005,    1'b1, 2'd2, 3'b100, 3'b010, 1'b1, 1'b0};
    vecs[6]  = '{3'b000, 1'b0, 1'b1, 1'b1, 64'h1111_0000_0000_0006,    1'b0, 2'd3, 3'b000, 3'b100, 1'b1, 1'b0};
    // stall lock on ch1; ch0 joins while locked
    vecs[7]  = '{3'b010, 1'b0, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 1'b0, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 1'b0, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd1, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[10] = '{3'b011, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd1, 3'b010, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b0};
    // error response to ch1, then ch0, then an orphan
    vecs[12] = '{3'b000, 1'b0, 1'b1, 1'b1, 64'h2222_0000_0000_000C,    1'b0, 2'd3, 3'b000, 3'b010, 1'b1, 1'b0};
    vecs[13] = '{3'b000, 1'b0, 1'b1, 1'b0, 64'h2222_0000_0000_000D,    1'b0, 2'd3, 3'b000, 3'b001, 1'b1, 1'b0};
    vecs[14] = '{3'b000, 1'b0, 1'b1, 1'b0, 64'h2222_0000_0000_000E,    1'b0, 2'd3, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[15] = '{3'b000, 1'b0, 1'b0, 1'b0, 64'h0,                      1'b0, 2'd3, 3'b000, 3'b000, 1'b0, 1'b1};
    // fill the tag FIFO (head = ch2), then pop+push in the same cycle
    vecs[16] = '{3'b100, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd2, 3'b100, 3'b000, 1'b0, 1'b1};
    vecs[17] = '{3'b001, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b1};
    vecs[18] = '{3'b001, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b1};
    vecs[19] = '{3'b001, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b1, 2'd0, 3'b001, 3'b000, 1'b1, 1'b1};
    vecs[20] = '{3'b001, 1'b1, 1'b0, 1'b0, 64'h0,                      1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 1'b1};
    vecs[21] = '{3'b001, 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001,    1'b1, 2'd0, 3'b001, 3'b100, 1'b1, 1'b1};
    vecs[22] = '{3'b000, 1'b0, 1'b0, 1'b0, 64'h0,                      1'b0, 2'd3, 3'b000, 3'b000, 1'b1, 1'b1};

    // reset held two cycles with every channel requesting
    drive(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, '0);
    chk_idle("rst0a");
    drive(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, '0);
    chk_idle("rst0b");

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, vecs[i].vld, vecs[i].rdy, vecs[i].rspv, vecs[i].rerr, vecs[i].rdata);
      chk_vec(i, vecs[i]);
      if (vecs[i].rspv && exp_q.size() > 0) begin
        logic [1:0] c;
        c = exp_q.pop_front();
        chk($sformatf("v%0d_sb_route", i), {63'd0, rspv_v[c]}, 64'd1);
      end
      for (int c = 0; c < 3; c++)
        if (vecs[i].rdyv[c]) exp_q.push_back(2'(c));
    end

    // reset with a full FIFO and the orphan flag set: everything reads 0
    drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 64'h5);
    chk_idle("rst1a");
    chk("rst1a_rdata2", rdata_o[2], 64'd0);
    drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 64'h5);
    chk_idle("rst1b");
    exp_q.delete();

    // first cycle out of reset: ch0 wins; the coincident response is an orphan, not bypassed
    drive(1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 64'h77);
    chk("post_rst_ready", {61'd0, rdy_v}, 64'd1);
    chk("post_rst_addr", {32'd0, mem_if.req_addr}, {32'd0, ch_addr[0]});
    chk("post_rst_rspv", {61'd0, rspv_v}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
    chk("push_orphan_flag", {63'd0, orphan}, 64'd1);
    chk("push_orphan_busy", {63'd0, busy}, 64'd1);

`ifdef DECODER_MEM_ARB_PERF_EN
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, '0);
    chk("perf_rst_g0", {32'd0, gc0}, 64'd0);
    for (int k = 0; k < 10; k++) drive(1'b0, 3'b001, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++)  drive(1'b0, 3'b100, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 7; k++)  drive(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
    chk("perf_g0", {32'd0, gc0}, 64'd10);
    chk("perf_g1", {32'd0, gc1}, 64'd0);
    chk("perf_g2", {32'd0, gc2}, 64'd5);
    chk("perf_stall", {32'd0, sc}, 64'd7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
